// File: rtl/pll_reset_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_ctrl_pkg
// Brief    : State encodings and helpers shared by the PLL reset sequencer and
//            by any debug/CSR logic that decodes its state output.
// Revision : 1.0 - initial release
// ============================================================================
package pll_reset_ctrl_pkg;

  // Width of the exported state field; software decodes the values below.
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage : pll_reset_ctrl_pkg
`default_nettype wire

// File: rtl/pll_reset_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Generic two-flop synchronizer, asynchronous active-low reset,
//            reset value 0. Output lags the input by two clk edges.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift the asynchronous input through the two synchronizing stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops; both clear while reset_ is low.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_ctrl
// Brief    : iCE40 PLL supervisor. Pulses RESETB, waits for LOCK with a
//            timeout and bounded retries, qualifies lock as stable, then
//            releases the SoC reset. Re-sequences on lock loss or on request.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_ctrl
  import pll_reset_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               pll_locked,
  input  logic               force_relock,
  output logic               pll_resetb,
  output logic               sys_reset_,
  output logic [STATE_W-1:0] state,
  output logic [1:0]         retry_cnt,
  output logic [7:0]         lock_loss_cnt,
  output logic               fail
);

  // Terminal counts: the counter starts at 0 on entry, so the last cycle of
  // an N-cycle interval sees N-1.
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  logic lock_s;

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             fail_q, fail_d;
  logic             restart;

  // LOCK is asynchronous to clk; every FSM decision uses the synchronized copy.
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk    (clk),
    .reset_ (reset_),
    .d      (pll_locked),
    .q      (lock_s)
  );

  // Next-state, counter and output decode. force_relock overrides every
  // lock/timeout event; re-entering RESET from RESET still restarts the count.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    restart = 1'b0;

    if (force_relock) begin
      state_d = ST_RESET;
      retry_d = 2'd0;
      restart = 1'b1;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_LIMIT) begin
              retry_d = retry_q + 2'd1;
              state_d = ST_RESET;
            end else begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_STABLE: begin
          // A dropout sends us back to wait; the retry budget is not charged.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = 2'd0;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET;
            loss_d  = sat_inc8(loss_q);
          end
        end
        ST_FAIL: begin
          // Only force_relock or reset_ leave FAIL.
        end
        default: begin
          state_d = ST_RESET;
          restart = 1'b1;
        end
      endcase
    end

    // Counter restarts on every transition; it has no meaning in RUN/FAIL so
    // it is frozen there rather than left to wrap.
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAIL)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Outputs are registered from the next state so they change in the same
    // cycle the state register does.
    pll_resetb_d = (state_d != ST_RESET);
    sys_rst_n_d  = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  // State and output registers; reset_ forces both reset pins low at once.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      retry_q      <= 2'd0;
      loss_q       <= 8'd0;
      pll_resetb_q <= 1'b0;
      sys_rst_n_q  <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= pll_resetb_d;
      sys_rst_n_q  <= sys_rst_n_d;
      fail_q       <= fail_d;
    end
  end

  assign state         = state_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign pll_resetb    = pll_resetb_q;
  assign sys_reset_    = sys_rst_n_q;
  assign fail          = fail_q;

endmodule : pll_reset_ctrl
`default_nettype wire

// File: tb/tb_pll_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_ctrl
// Brief    : Self-checking bench for pll_reset_ctrl. Expected state
//            transitions (with their cycle offset and output snapshot) are
//            queued before stimulus and popped as the DUT changes state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_ctrl;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  logic       clk;
  logic       reset_;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_resetb;
  logic       sys_reset_;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic       fail;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  typedef struct {
    logic [2:0] st;
    int         cyc_at;
    logic       pllrb;
    logic       sysr;
    logic [1:0] retry;
    logic       fl;
  } exp_t;

  exp_t exp_q[$];

  pll_reset_ctrl #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .reset_        (reset_),
    .pll_locked    (pll_locked),
    .force_relock  (force_relock),
    .pll_resetb    (pll_resetb),
    .sys_reset_    (sys_reset_),
    .state         (state),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .fail          (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic expect_tr(input logic [2:0] st, input int at, input logic pllrb,
                           input logic sysr, input logic [1:0] retry, input logic fl);
    exp_t e;
    e.st = st; e.cyc_at = at; e.pllrb = pllrb; e.sysr = sysr; e.retry = retry; e.fl = fl;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: each observed state change pops the next expectation.
  task automatic watch(input string name, input int ncyc);
    logic [2:0] last;
    exp_t e;
    last = state;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      if (state !== last) begin
        last = state;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s: unexpected transition to state=%0d at cycle %0d", name, state, cyc - t0);
        end else begin
          e = exp_q.pop_front();
          if (state !== e.st || (cyc - t0) != e.cyc_at || pll_resetb !== e.pllrb ||
              sys_reset_ !== e.sysr || retry_cnt !== e.retry || fail !== e.fl) begin
            errors++;
            $display("FAIL %s: got state=%0d cyc=%0d pll_resetb=%b sys_reset_=%b retry=%0d fail=%b, want state=%0d cyc=%0d pll_resetb=%b sys_reset_=%b retry=%0d fail=%b",
                     name, state, cyc - t0, pll_resetb, sys_reset_, retry_cnt, fail,
                     e.st, e.cyc_at, e.pllrb, e.sysr, e.retry, e.fl);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected transitions missing, next want state=%0d at cycle %0d",
               name, exp_q.size(), exp_q[0].st, exp_q[0].cyc_at);
      exp_q.delete();
    end
  endtask

  // Pulse reset_ low for two cycles; t0 marks the release point.
  task automatic restart_dut();
    @(posedge clk); #1;
    reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
    t0 = cyc;
  endtask

  task automatic test_reset();
    reset_ = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({state, pll_resetb, sys_reset_, fail, retry_cnt, lock_loss_cnt} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: got state=%0d pll_resetb=%b sys_reset_=%b fail=%b retry=%0d loss=%0d, want all 0",
               state, pll_resetb, sys_reset_, fail, retry_cnt, lock_loss_cnt);
    end
  endtask

  // Lock raised 10 cycles after release: 2 sync + 1 decision + 8 stable -> RUN at 21.
  task automatic test_lock_sequence();
    pll_locked = 1'b0;
    restart_dut();
    checks++;
    if (state !== S_RESET || pll_resetb !== 1'b0 || sys_reset_ !== 1'b0) begin
      errors++;
      $display("FAIL seq_release: got state=%0d pll_resetb=%b sys_reset_=%b, want 0 0 0", state, pll_resetb, sys_reset_);
    end
    expect_tr(S_WAIT,    4, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_STABLE, 13, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_RUN,    21, 1'b1, 1'b1, 2'd0, 1'b0);
    fork
      watch("lock_seq", 25);
      begin repeat (10) @(posedge clk); #1 pll_locked = 1'b1; end
    join
  endtask

  task automatic test_timeout_fail();
    pll_locked = 1'b0;
    restart_dut();
    expect_tr(S_WAIT,    4, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_RESET,  24, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_tr(S_WAIT,   28, 1'b1, 1'b0, 2'd1, 1'b0);
    expect_tr(S_RESET,  48, 1'b0, 1'b0, 2'd2, 1'b0);
    expect_tr(S_WAIT,   52, 1'b1, 1'b0, 2'd2, 1'b0);
    expect_tr(S_FAIL,   72, 1'b1, 1'b0, 2'd2, 1'b1);
    watch("timeout", 90);
  endtask

  // force_relock lands on the very edge where lock_s is first seen high.
  task automatic test_force_from_fail();
    pll_locked = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_relock = 1'b1;
    @(posedge clk); #1;
    force_relock = 1'b0;
    checks++;
    if (state !== S_RESET || retry_cnt !== 2'd0 || pll_resetb !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL force_fail: got state=%0d retry=%0d pll_resetb=%b fail=%b, want 0 0 0 0",
               state, retry_cnt, pll_resetb, fail);
    end
    t0 = cyc;
    expect_tr(S_WAIT,    4, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_STABLE,  5, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_RUN,    13, 1'b1, 1'b1, 2'd0, 1'b0);
    watch("force_fail_seq", 16);
  endtask

  // Lock dropped for 3 cycles while STABLE; stable count must restart.
  task automatic test_stable_glitch();
    pll_locked = 1'b1;
    restart_dut();
    expect_tr(S_WAIT,    4, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_STABLE,  5, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_WAIT,    9, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_STABLE, 12, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_RUN,    20, 1'b1, 1'b1, 2'd0, 1'b0);
    fork
      watch("stable_glitch", 24);
      begin
        repeat (6) @(posedge clk); #1 pll_locked = 1'b0;
        repeat (3) @(posedge clk); #1 pll_locked = 1'b1;
      end
    join
  endtask

  task automatic test_lock_loss();
    int want;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      t0 = cyc;
      expect_tr(S_RESET, 3, 1'b0, 1'b0, 2'd0, 1'b0);
      watch("loss_drop", 3);
      want = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (lock_loss_cnt !== 8'(want)) begin
        errors++;
        $display("FAIL loss_count: iter %0d got %0d want %0d", i, lock_loss_cnt, want);
      end
      pll_locked = 1'b1;
      t0 = cyc;
      expect_tr(S_WAIT,    4, 1'b1, 1'b0, 2'd0, 1'b0);
      expect_tr(S_STABLE,  5, 1'b1, 1'b0, 2'd0, 1'b0);
      expect_tr(S_RUN,    13, 1'b1, 1'b1, 2'd0, 1'b0);
      watch("loss_relock", 13);
    end
  endtask

  task automatic test_async_reset();
    pll_locked = 1'b1;
    restart_dut();
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (state !== S_STABLE || pll_resetb !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got state=%0d pll_resetb=%b, want 2 1", state, pll_resetb);
    end
    #3 reset_ = 1'b0;
    #1;
    checks++;
    if (pll_resetb !== 1'b0 || sys_reset_ !== 1'b0 || state !== S_RESET || lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_assert: got pll_resetb=%b sys_reset_=%b state=%0d loss=%0d, want 0 0 0 0",
               pll_resetb, sys_reset_, state, lock_loss_cnt);
    end
    @(posedge clk); #1;
    reset_ = 1'b1;
    t0 = cyc;
    expect_tr(S_WAIT,    4, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_STABLE,  5, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_RUN,    13, 1'b1, 1'b1, 2'd0, 1'b0);
    watch("async_release", 15);
  endtask

  // Second force while already in RESET pushes WAIT_LOCK out to cycle 7.
  task automatic test_force_in_reset();
    t0 = cyc;
    force_relock = 1'b1;
    expect_tr(S_RESET,   1, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_tr(S_WAIT,    7, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_STABLE,  8, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_tr(S_RUN,    16, 1'b1, 1'b1, 2'd0, 1'b0);
    fork
      watch("force_reset", 18);
      begin
        @(posedge clk); #1 force_relock = 1'b0;
        @(posedge clk); #1 force_relock = 1'b1;
        @(posedge clk); #1 force_relock = 1'b0;
      end
    join
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL force_loss: got lock_loss_cnt=%0d want 0", lock_loss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_timeout_fail();
    test_force_from_fail();
    test_stable_glitch();
    test_lock_loss();
    test_async_reset();
    test_force_in_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pll_reset_ctrl
`default_nettype wire
